// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencer for the 5-stage RV32I core.
//   Inputs:  clk_i, rst_ni (async, active-low); ID sources/uses, EX rd/memread/branch_taken,
//            I/D-cache busy.
//   Outputs: stage write enables, IF/ID flush, control_zero_sel_o, sticky timeout_o,
//            saturating stall-cycle and branch-flush counters.
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int TIMEOUT     = 1024,
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [REG_ADDR_W-1:0]  id_rs1_i,
   input  logic [REG_ADDR_W-1:0]  id_rs2_i,
   input  logic                   id_uses_rs1_i,
   input  logic                   id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0]  ex_rd_i,
   input  logic                   ex_memread_i,
   input  logic                   ex_branch_taken_i,
   input  logic                   icache_busy_i,
   input  logic                   dcache_busy_i,
   output logic                   pc_write_o,
   output logic                   ifid_write_o,
   output logic                   ifid_flush_o,
   output logic                   control_zero_sel_o,
   output logic                   idex_write_o,
   output logic                   exmem_write_o,
   output logic                   memwb_write_o,
   output logic                   timeout_o,
   output logic [STALL_CNT_W-1:0] stall_cycles_o,
   output logic [FLUSH_CNT_W-1:0] flush_count_o
);
   localparam int WD_W = $clog2(TIMEOUT);
   typedef enum logic [1:0] {RUN, DSTALL, ISTALL, HUNG} state_t;
   state_t state, state_nxt;
   logic [WD_W-1:0] wdog;
   logic load_use, stalled, busy, hit, br_flush, down;
   assign load_use = ex_memread_i & (ex_rd_i != '0) &
                     ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
   assign stalled  = (state == DSTALL) | (state == ISTALL);
   assign busy     = icache_busy_i | dcache_busy_i;
   assign hit      = stalled & busy & (wdog == WD_W'(TIMEOUT - 1));
   assign br_flush = (state != HUNG) & ~dcache_busy_i & ex_branch_taken_i;
   assign idex_write_o  = down;
   assign exmem_write_o = down;
   assign memwb_write_o = down;
   // Outputs are Mealy; reset is folded in combinationally so an async reset shows at once.
   always_comb begin
      pc_write_o         = 1'b1;
      ifid_write_o       = 1'b1;
      ifid_flush_o       = 1'b0;
      control_zero_sel_o = 1'b0;
      down               = 1'b1;
      if (!rst_ni || state == HUNG) begin
         pc_write_o         = 1'b0;
         ifid_write_o       = 1'b0;
         down               = 1'b0;
         control_zero_sel_o = 1'b1;
      end else if (dcache_busy_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         down         = 1'b0;
      end else if (ex_branch_taken_i) begin
         ifid_flush_o       = 1'b1;
         control_zero_sel_o = 1'b1;
      end else if (load_use) begin
         pc_write_o         = 1'b0;
         ifid_write_o       = 1'b0;
         control_zero_sel_o = 1'b1;
      end else if (icache_busy_i) begin
         pc_write_o   = 1'b0;
         ifid_flush_o = 1'b1;
      end
   end
   // A branch taken in RUN keeps us out of ISTALL; once in ISTALL only the caches matter.
   always_comb
      state_nxt = (state == HUNG || hit) ? HUNG :
                  dcache_busy_i ? DSTALL :
                  (icache_busy_i && !(state == RUN && ex_branch_taken_i)) ? ISTALL : RUN;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= RUN;
         wdog           <= '0;
         timeout_o      <= 1'b0;
         stall_cycles_o <= '0;
         flush_count_o  <= '0;
      end else begin
         state     <= state_nxt;
         timeout_o <= timeout_o | hit;
         wdog      <= (state_nxt == RUN) ? '0 : (stalled && busy) ? wdog + 1'b1 : wdog;
         if (!pc_write_o && state != HUNG && !(&stall_cycles_o))
            stall_cycles_o <= stall_cycles_o + 1'b1;
         if (br_flush && !(&flush_count_o))
            flush_count_o <= flush_count_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, ib = 1'b0, db = 1'b0;
   logic pc_w, ifid_w, ifid_f, czs, idex_w, exmem_w, memwb_w, tmo;
   logic [3:0] stall_c;
   logic [15:0] flush_c;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   hazard_stall_ctrl #(.REG_ADDR_W(5), .TIMEOUT(8), .STALL_CNT_W(4), .FLUSH_CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_i(rd), .ex_memread_i(mr), .ex_branch_taken_i(br),
      .icache_busy_i(ib), .dcache_busy_i(db),
      .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
      .control_zero_sel_o(czs), .idex_write_o(idex_w), .exmem_write_o(exmem_w),
      .memwb_write_o(memwb_w), .timeout_o(tmo),
      .stall_cycles_o(stall_c), .flush_count_o(flush_c)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // {pc, ifid, flush, czs, idex, exmem, memwb}
   function automatic logic [6:0] outs();
      return {pc_w, ifid_w, ifid_f, czs, idex_w, exmem_w, memwb_w};
   endfunction
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                        input logic [4:0] d, input logic m, input logic t, input logic i, input logic c);
      rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; mr = m; br = t; ib = i; db = c;
      #1;
   endtask
   task automatic reset_pulse();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      #1;
      check("reset_outs", 32'(outs()), 32'b0001000);
      check("reset_timeout", 32'(tmo), 0);
      check("reset_stall", 32'(stall_c), 0);
      tick();
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("idle_outs", 32'(outs()), 32'b1100111);
      // load-use: lw x5 in EX, add x6,x5,x7 in ID
      drive(5, 7, 1, 1, 5, 1, 0, 0, 0);
      check("lu_outs", 32'(outs()), 32'b0001111);
      tick();
      check("lu_stall_cnt", 32'(stall_c), 1);
      drive(5, 7, 1, 1, 5, 0, 0, 0, 0);
      check("lu_bubble_outs", 32'(outs()), 32'b1100111);
      tick();
      check("lu_stall_once", 32'(stall_c), 1);
      drive(0, 0, 1, 1, 0, 1, 0, 0, 0);
      check("x0_guard", 32'(outs()), 32'b1100111);
      drive(3, 5, 1, 0, 5, 1, 0, 0, 0);
      check("unused_rs2", 32'(outs()), 32'b1100111);
      // branch together with load-use
      drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
      check("br_lu_outs", 32'(outs()), 32'b1111111);
      tick();
      check("br_flush_cnt", 32'(flush_c), 1);
      check("br_no_stall", 32'(stall_c), 1);
      // 4-cycle D-cache miss with taken branch held in EX
      reset_pulse();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("dmiss_freeze%0d", i), 32'(outs()), 32'b0000000);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("dmiss_release", 32'(outs()), 32'b1111111);
      tick();
      check("dmiss_flush_cnt", 32'(flush_c), 1);
      check("dmiss_stall_cnt", 32'(stall_c), 4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("dmiss_run", 32'(outs()), 32'b1100111);
      // watchdog with TIMEOUT=8
      reset_pulse();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("imiss_outs", 32'(outs()), 32'b0110111);
      for (int i = 0; i < 8; i++) tick();
      check("wd_not_yet", 32'(tmo), 0);
      tick();
      check("wd_timeout", 32'(tmo), 1);
      check("wd_hung_outs", 32'(outs()), 32'b0001000);
      check("wd_stall_cnt", 32'(stall_c), 9);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("hung_sticky_outs", 32'(outs()), 32'b0001000);
      tick();
      check("hung_sticky_tmo", 32'(tmo), 1);
      check("hung_no_count", 32'(stall_c), 9);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_outs", 32'(outs()), 32'b0001000);
      check("midrst_tmo", 32'(tmo), 0);
      check("midrst_stall", 32'(stall_c), 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_run", 32'(outs()), 32'b1100111);
      // stall counter saturation: persistent load-use for 20 cycles
      tick();
      reset_pulse();
      drive(9, 0, 1, 0, 9, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      check("stall_saturate", 32'(stall_c), 15);
      check("lu_no_timeout", 32'(tmo), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Detects load-use hazards, EX-stage taken branches, and I/D-cache miss stalls.
- Drives the stage-register write enables, the IF/ID flush, and controlZeroSel for the control-zeroing mux at the ID/EX boundary.
- Adds a stall FSM, a stall watchdog and saturating performance counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- TIMEOUT, 1024, consecutive stall cycles before the pipeline is declared hung (must be ≥2).
- STALL_CNT_W, 32, width of the stall-cycle counter.
- FLUSH_CNT_W, 16, width of the flush counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- id_rs1_i  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2_i  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_uses_rs1_i  in  1  ID instruction reads rs1.
- id_uses_rs2_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- icache_busy_i  in  1  fetch miss outstanding.
- dcache_busy_i  in  1  data access miss outstanding.
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID enable.
- ifid_flush_o  out  1  IF/ID loads NOP.
- control_zero_sel_o  out  1  zeroes ID/EX control bits.
- idex_write_o  out  1  ID/EX enable.
- exmem_write_o  out  1  EX/MEM enable.
- memwb_write_o  out  1  MEM/WB enable.
- timeout_o  out  1  sticky hang flag.
- stall_cycles_o  out  STALL_CNT_W  saturating count of cycles with pc_write_o=0.
- flush_count_o  out  FLUSH_CNT_W  saturating count of branch flushes.

Behaviour:
- Clocking and reset: single clock; reset asynchronous, active-low.
- While rst_ni=0:
  - State = RUN; counters = 0; timeout_o = 0.
  - All *_write_o = 0, ifid_flush_o = 0, control_zero_sel_o = 1.
- Outputs are combinational from state and inputs (Mealy), i.e. zero-cycle latency. Registered elements are the state, watchdog counter, timeout_o and performance counters.
- load_use = ex_memread_i & (ex_rd_i≠0) & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i)).
- Priority in RUN/ISTALL/DSTALL, highest first:
  1. dcache_busy_i: freeze. All *_write_o=0, flush=0, control_zero_sel_o=0. A taken branch held in the frozen EX is acted on in the first cycle busy is low.
  2. ex_branch_taken_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, control_zero_sel_o=1, downstream enables=1. flush_count_o increments.
  3. load_use: pc_write_o=0, ifid_write_o=0, control_zero_sel_o=1, idex/exmem/memwb=1. This is exactly one bubble; the next cycle EX holds the bubble (memread=0), so the hazard clears.
  4. icache_busy_i: pc_write_o=0, ifid_write_o=1, ifid_flush_o=1, control_zero_sel_o=0, downstream=1. The pipeline drains; fetch holds.
  5. None of the above: all enables=1, flush=0, control_zero_sel_o=0.
- FSM states: RUN, DSTALL, ISTALL, HUNG.
  - RUN → DSTALL if dcache_busy_i.
  - RUN → ISTALL if icache_busy_i & !dcache_busy_i & !ex_branch_taken_i.
  - DSTALL → RUN when !dcache_busy_i (→ ISTALL if icache_busy_i).
  - ISTALL → DSTALL if dcache_busy_i; → RUN if !icache_busy_i.
  - Any stall state → HUNG when wdog == TIMEOUT-1 and the stall condition is still present.
  - HUNG: all *_write_o=0, flush=0, control_zero_sel_o=1, timeout_o=1. Exit only by reset.
- Watchdog wdog (clog2(TIMEOUT) bits):
  - Increments each cycle in DSTALL/ISTALL with busy still asserted.
  - Clears on entry to RUN.
  - Does not clear on a DSTALL↔ISTALL transition.
- Branch taken during ISTALL: branch wins (rule 2). The FSM stays ISTALL while icache_busy_i persists.
- stall_cycles_o: +1 each cycle pc_write_o=0 outside reset and HUNG; saturates at all-ones.
- flush_count_o: saturates at all-ones.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x7 (rs1=5, uses_rs1=1) → exactly 1 cycle with pc_write_o=0, ifid_write_o=0, control_zero_sel_o=1; next cycle all enables 1; stall_cycles_o=1.
- x0 and unused-source guard: ex_rd_i=0 with id_rs1_i=0, or rd matching rs2 while uses_rs2=0 → no stall, control_zero_sel_o=0.
- Branch plus load-use in the same cycle: ex_branch_taken_i=1 with load_use=1 → ifid_flush_o=1, pc_write_o=1, control_zero_sel_o=1; flush_count_o 0→1.
- D-cache miss of 4 cycles with a branch taken in EX → 4 cycles of all enables 0 in DSTALL; 5th cycle flush asserted; state RUN.
- Watchdog: TIMEOUT=8, icache_busy_i held high → timeout_o=1 after 8 stall cycles, outputs frozen; releasing busy has no effect until rst_ni pulses low mid-cycle, after which outputs immediately show reset values.
- Saturation: STALL_CNT_W=4, 20 stall cycles → stall_cycles_o=15.
